// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU writeback stage: condition check, flag register, 2-entry result buffer
// Optional op/squash counters are enabled by defining ALU_RESULT_STAGE_STATS_EN.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_flags,
  input  logic [3:0]       in_rd,
  input  logic             in_setflags,
  input  logic [3:0]       in_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_rd,
  output logic             out_we,
  output logic [3:0]       flags_q
`ifdef ALU_RESULT_STAGE_STATS_EN
  ,
  output logic [15:0]      op_count,
  output logic [15:0]      squash_count
`endif
);

  logic [WIDTH-1:0] mem_result [DEPTH];
  logic [3:0]       mem_rd     [DEPTH];
  logic             mem_pass   [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;
  logic             pass;

  // Flags are {N,Z,C,V}; evaluated against the architectural register only.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready   = (count < 2'd2);
  assign out_valid  = (count != 2'd0);
  assign out_result = mem_result[rd_ptr];
  assign out_rd     = mem_rd[rd_ptr];
  assign out_we     = out_valid && mem_pass[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign pass = cond_pass(in_cond, flags_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= '0;
        mem_rd[i]     <= '0;
        mem_pass[i]   <= 1'b0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      flags_q <= 4'b0000;
    end else begin
      if (push) begin
        mem_result[wr_ptr] <= in_result;
        mem_rd[wr_ptr]     <= in_rd;
        mem_pass[wr_ptr]   <= pass;
        wr_ptr             <= ~wr_ptr;
        if (in_setflags && pass) begin
          flags_q <= in_flags;
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

`ifdef ALU_RESULT_STAGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count     <= 16'd0;
      squash_count <= 16'd0;
    end else if (push) begin
      op_count <= op_count + 16'd1;
      if (!pass) begin
        squash_count <= squash_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
// Build with ALU_RESULT_STAGE_STATS_EN defined to also check the counters.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [3:0]  in_rd;
  logic        in_setflags;
  logic [3:0]  in_cond;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_we;
  logic [3:0]  flags_q;
`ifdef ALU_RESULT_STAGE_STATS_EN
  logic [15:0] op_count;
  logic [15:0] squash_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_ops = 0;
  int exp_squash = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_rd(in_rd), .in_setflags(in_setflags), .in_cond(in_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .flags_q(flags_q)
`ifdef ALU_RESULT_STAGE_STATS_EN
    , .op_count(op_count), .squash_count(squash_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] res, input logic [3:0] rd, input logic [3:0] cond,
                       input logic sf, input logic [3:0] fl);
    in_valid    = 1'b1;
    in_result   = res;
    in_rd       = rd;
    in_cond     = cond;
    in_setflags = sf;
    in_flags    = fl;
  endtask

  // Single op through an empty buffer with out_ready=1; checks head and flag register.
  task automatic push_check(input string tag, input logic [31:0] res, input logic [3:0] rd,
                            input logic [3:0] cond, input logic sf, input logic [3:0] fl,
                            input logic exp_we, input logic [3:0] exp_flags);
    drive(res, rd, cond, sf, fl);
    exp_ops++;
    if (!exp_we) exp_squash++;
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, out_result, res);
    check({tag, "_we"}, 32'(out_we), 32'(exp_we));
    check({tag, "_flags"}, 32'(flags_q), 32'(exp_flags));
    step();
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_result = '0; in_flags = '0; in_rd = '0;
    in_setflags = 1'b0; in_cond = '0; out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_we", 32'(out_we), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic one-cycle latency, always-condition
    drive(32'd5, 4'd3, 4'hE, 1'b1, 4'b0000);
    exp_ops++;
    step();
    in_valid = 1'b0;
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_result", out_result, 32'd5);
    check("basic_rd", 32'(out_rd), 32'd3);
    check("basic_we", 32'(out_we), 32'd1);
    check("basic_flags", 32'(flags_q), 32'd0);
    step();
    check("basic_empty_valid", 32'(out_valid), 32'd0);
    check("basic_empty_we", 32'(out_we), 32'd0);

    // Back-to-back: set Z, then EQ passes, then NE fails without touching flags
    drive(32'd10, 4'd1, 4'hE, 1'b1, 4'b0100);
    exp_ops++;
    step();
    check("z_flags", 32'(flags_q), 32'h4);
    check("z_we", 32'(out_we), 32'd1);
    drive(32'd11, 4'd2, 4'h0, 1'b0, 4'b0000);
    exp_ops++;
    step();
    check("eq_result", out_result, 32'd11);
    check("eq_rd", 32'(out_rd), 32'd2);
    check("eq_we", 32'(out_we), 32'd1);
    drive(32'd12, 4'd4, 4'h1, 1'b1, 4'b1111);
    exp_ops++; exp_squash++;
    step();
    in_valid = 1'b0;
    check("ne_result", out_result, 32'd12);
    check("ne_we", 32'(out_we), 32'd0);
    check("ne_flags", 32'(flags_q), 32'h4);
    step();
    check("ne_drained", 32'(out_valid), 32'd0);

    // Condition table sweep; flags start at 0100
    push_check("gt",  32'd30, 4'd1,  4'hC, 1'b0, 4'b0000, 1'b0, 4'b0100);
    push_check("le",  32'd31, 4'd2,  4'hD, 1'b1, 4'b1001, 1'b1, 4'b1001);
    push_check("ge",  32'd32, 4'd3,  4'hA, 1'b0, 4'b0000, 1'b1, 4'b1001);
    push_check("lt",  32'd33, 4'd4,  4'hB, 1'b0, 4'b0000, 1'b0, 4'b1001);
    push_check("cs",  32'd34, 4'd5,  4'h2, 1'b0, 4'b0000, 1'b0, 4'b1001);
    push_check("mi",  32'd35, 4'd6,  4'h4, 1'b0, 4'b0000, 1'b1, 4'b1001);
    push_check("hi0", 32'd36, 4'd7,  4'h8, 1'b0, 4'b0000, 1'b0, 4'b1001);
    push_check("ls",  32'd37, 4'd8,  4'h9, 1'b1, 4'b0010, 1'b1, 4'b0010);
    push_check("hi1", 32'd38, 4'd9,  4'h8, 1'b0, 4'b0000, 1'b1, 4'b0010);
    push_check("vs",  32'd39, 4'd10, 4'h6, 1'b1, 4'b1111, 1'b0, 4'b0010);
    push_check("cc",  32'd40, 4'd11, 4'h3, 1'b0, 4'b0000, 1'b0, 4'b0010);
`ifdef ALU_RESULT_STAGE_STATS_EN
    check("op_count", 32'(op_count), 32'(exp_ops));
    check("squash_count", 32'(squash_count), 32'(exp_squash));
`endif

    // Backpressure: fill, stall third, then drain in order
    out_ready = 1'b0;
    drive(32'd20, 4'd5, 4'hE, 1'b0, 4'b0000);
    step();
    drive(32'd21, 4'd6, 4'hE, 1'b0, 4'b0000);
    step();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_result, 32'd20);
    drive(32'd22, 4'd7, 4'hE, 1'b0, 4'b0000);
    step();
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_head", out_result, 32'd20);
    check("stall_rd", 32'(out_rd), 32'd5);
    step();
    check("stall2_head", out_result, 32'd20);
    check("stall2_we", 32'(out_we), 32'd1);
    out_ready = 1'b1;
    step();
    check("drain1_head", out_result, 32'd21);
    check("drain1_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("drain2_head", out_result, 32'd22);
    check("drain2_rd", 32'(out_rd), 32'd7);
    check("drain2_valid", 32'(out_valid), 32'd1);
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    drive(32'd50, 4'd12, 4'hE, 1'b1, 4'b1010);
    step();
    drive(32'd51, 4'd13, 4'hE, 1'b0, 4'b0000);
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_flags", 32'(flags_q), 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_flags", 32'(flags_q), 32'd0);
    check("arst_we", 32'(out_we), 32'd0);
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_result", out_result, 32'd0);
    check("post_rst_rd", 32'(out_rd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
